pad_input_conditioner: RTL and testbench

//  Sits directly downstream of a functional pad model: consumes the pad's asynchronous O output.
//  - Synchronises O into the clk_i domain.
//  - Debounces it against a runtime glitch threshold.
//  - Presents a clean filtered level plus one-cycle rise/fall pulses to core logic
//    (GPIO, wake-up, interrupt controllers).

---
 rtl/pad_input_conditioner.sv | 88 ++++++++
 tb/tb_pad_input_conditioner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: synchroniser, runtime-threshold debouncer and edge pulses.
// Optional sticky edge-capture flag under `PAD_INPUT_CONDITIONER_CAPTURE_EN.
module pad_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pad_o_i,
    input  logic [DEBOUNCE_W-1:0] debounce_th_i,
`ifdef PAD_INPUT_CONDITIONER_CAPTURE_EN
    input  logic [1:0]            edge_cfg_i,
    input  logic                  event_clr_i,
    output logic                  event_o,
`endif
    output logic                  filt_o,
    output logic                  rise_o,
    output logic                  fall_o,
    output logic                  busy_o
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pad_input_conditioner: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   sync_level;
    logic                   differ;
    logic                   accept;

    // Pad feeds the first flop directly; nothing combinational ahead of it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_o_i};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign differ     = (sync_level != filt_o);
    // >= so a threshold lowered below the running count accepts at once.
    assign accept     = differ && (cnt >= debounce_th_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_o <= RESET_VALUE;
            cnt    <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            busy_o <= (cnt != '0);
            rise_o <= accept && sync_level;
            fall_o <= accept && !sync_level;
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            if (accept) begin
                filt_o <= sync_level;
            end
        end
    end

`ifdef PAD_INPUT_CONDITIONER_CAPTURE_EN
    logic capture;

    assign capture = (rise_o && edge_cfg_i[0]) || (fall_o && edge_cfg_i[1]);

    // A new capture outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_o <= 1'b0;
        end else if (capture) begin
            event_o <= 1'b1;
        end else if (event_clr_i) begin
            event_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench for pad_input_conditioner: directed pad patterns with
// hand-derived per-edge expectations, popped by a negedge monitor.
module tb_pad_input_conditioner;

    logic       clk;
    logic       rst;
    logic       pad;
    logic [7:0] th;
    logic [1:0] cfg;
    logic       clr;
    logic       evt;
    logic       filt;
    logic       rise;
    logic       fall;
    logic       busy;

    pad_input_conditioner #(
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (8),
        .RESET_VALUE (1'b0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pad_o_i       (pad),
        .debounce_th_i (th),
`ifdef PAD_INPUT_CONDITIONER_CAPTURE_EN
        .edge_cfg_i    (cfg),
        .event_clr_i   (clr),
        .event_o       (evt),
`endif
        .filt_o        (filt),
        .rise_o        (rise),
        .fall_o        (fall),
        .busy_o        (busy)
    );

`ifndef PAD_INPUT_CONDITIONER_CAPTURE_EN
    assign evt = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bits: {event, filt, rise, fall, busy}
    typedef struct {
        string      nm;
        int         at;
        logic [4:0] exp;
        logic [4:0] mask;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   edge_n   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   b;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input int at, input int f,
                       input int r, input int fa, input int bz,
                       input int ev = -1);
        exp_t e;
        int   i;
        e.nm   = nm;
        e.at   = at;
        e.exp  = '0;
        e.mask = '0;
        if (f >= 0)  begin e.exp[3] = f[0];  e.mask[3] = 1'b1; end
        if (r >= 0)  begin e.exp[2] = r[0];  e.mask[2] = 1'b1; end
        if (fa >= 0) begin e.exp[1] = fa[0]; e.mask[1] = 1'b1; end
        if (bz >= 0) begin e.exp[0] = bz[0]; e.mask[0] = 1'b1; end
`ifdef PAD_INPUT_CONDITIONER_CAPTURE_EN
        if (ev >= 0) begin e.exp[4] = ev[0]; e.mask[4] = 1'b1; end
`endif
        i = 0;
        while (i < q.size() && q[i].at <= at) i++;
        q.insert(i, e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_n) begin
            cur = q.pop_front();
            checks++;
            if (cur.at != edge_n) begin
                failures++;
                $display("FAIL %s: expectation for edge %0d seen at edge %0d",
                         cur.nm, cur.at, edge_n);
            end else if (({evt, filt, rise, fall, busy} & cur.mask)
                         !== (cur.exp & cur.mask)) begin
                failures++;
                $display("FAIL %s @edge %0d: got ev/filt/rise/fall/busy=%b required %b (mask %b)",
                         cur.nm, edge_n, {evt, filt, rise, fall, busy},
                         cur.exp, cur.mask);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d expectations pending, required 0",
                     q.size());
            q.delete();
        end
    endtask

    task automatic start(output int base);
        @(posedge clk);
        #1;
        base = edge_n;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pad = 1'b1;
        th  = 8'd3;
        cfg = 2'b10;
        clr = 1'b0;

        // Reset held three edges with the pad already high
        for (int k = 1; k <= 3; k++) chk("reset_hold", k, 0, 0, 0, 0, 0);
        edges(3);
        rst = 1'b0;
        b = edge_n;
        for (int k = 1; k <= 5; k++) chk("reset_release_wait", b + k, 0, 0, 0, -1);
        chk("reset_release_rise", b + 6, 1, 1, 0, -1);
        chk("reset_release_after", b + 7, 1, 0, 0, 0);
        drain();

        start(b);
        chk("return_low_fall", b + 6, 0, 0, 1, -1);
        chk("return_low_after", b + 7, 0, 0, 0, 0);
        pad = 1'b0;
        drain();

        // Clean rising edge, N=3
        start(b);
        chk("clean_e3", b + 3, 0, 0, 0, 0);
        chk("clean_e4", b + 4, 0, 0, 0, 1);
        chk("clean_e5", b + 5, 0, 0, 0, 1);
        chk("clean_e6", b + 6, 1, 1, 0, 1);
        chk("clean_e7", b + 7, 1, 0, 0, 0);
        pad = 1'b1;
        drain();

        start(b);
        chk("clean_fall", b + 6, 0, 0, 1, -1);
        pad = 1'b0;
        drain();

        // Glitch of N cycles is rejected
        start(b);
        for (int k = 1; k <= 8; k++)
            chk("glitch3", b + k, 0, 0, 0, (k >= 4 && k <= 6) ? 1 : 0);
        pad = 1'b1;
        edges(3);
        pad = 1'b0;
        drain();

        // N+1 cycles passes, then the fall qualifies
        start(b);
        chk("pulse4_pre", b + 5, 0, 0, 0, 1);
        chk("pulse4_rise", b + 6, 1, 1, 0, 1);
        chk("pulse4_hold", b + 7, 1, 0, 0, -1);
        chk("pulse4_wait", b + 9, 1, 0, 0, 1);
        chk("pulse4_fall", b + 10, 0, 0, 1, 1);
        chk("pulse4_after", b + 11, 0, 0, 0, -1);
        pad = 1'b1;
        edges(4);
        pad = 1'b0;
        drain();

        // N=0: straight 3-cycle delay
        th = 8'd0;
        start(b);
        chk("n0_e1", b + 1, 0, 0, 0, 0);
        chk("n0_e2", b + 2, 0, 0, 0, 0);
        chk("n0_rise", b + 3, 1, 1, 0, 0);
        chk("n0_hold", b + 4, 1, 0, 0, 0);
        chk("n0_fall", b + 5, 0, 0, 1, 0);
        chk("n0_after", b + 6, 0, 0, 0, 0);
        pad = 1'b1;
        edges(2);
        pad = 1'b0;
        drain();

        // N=255: 255 cycles rejected
        th = 8'd255;
        start(b);
        chk("n255_rej_e257", b + 257, 0, 0, 0, 1);
        chk("n255_rej_e258", b + 258, 0, 0, 0, 1);
        chk("n255_rej_e259", b + 259, 0, 0, 0, 0);
        chk("n255_rej_e260", b + 260, 0, 0, 0, 0);
        pad = 1'b1;
        edges(255);
        pad = 1'b0;
        drain();

        // N=255: 256 cycles accepted, fall 256 cycles later
        start(b);
        chk("n255_acc_e257", b + 257, 0, 0, 0, 1);
        chk("n255_acc_rise", b + 258, 1, 1, 0, 1);
        chk("n255_acc_e259", b + 259, 1, 0, 0, 0);
        chk("n255_acc_e513", b + 513, 1, 0, 0, 1);
        chk("n255_acc_fall", b + 514, 0, 0, 1, 1);
        chk("n255_acc_e515", b + 515, 0, 0, 0, 0);
        pad = 1'b1;
        edges(256);
        pad = 1'b0;
        drain();

        // Threshold lowered 10 -> 2 while the count sits at 5
        th = 8'd10;
        start(b);
        chk("lower_th_pre", b + 7, 0, 0, 0, 1);
        chk("lower_th_rise", b + 8, 1, 1, 0, 1);
        chk("lower_th_after", b + 9, 1, 0, 0, -1);
        pad = 1'b1;
        edges(7);
        th = 8'd2;
        drain();

        // Reset mid-count from filt=1: forced low, no fall pulse
        th = 8'd5;
        start(b);
        chk("rst_mid_pre", b + 4, 1, 0, 0, 1);
        chk("rst_mid_forced", b + 5, 0, 0, 0, 0, 0);
        chk("rst_mid_e6", b + 6, 0, 0, 0, 0, 0);
        chk("rst_mid_e8", b + 8, 0, 0, 0, 0);
        pad = 1'b0;
        edges(4);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        drain();

        // Reset mid-count from filt=0: count discarded, re-qualifies from scratch
        start(b);
        chk("rst_requal_pre", b + 4, 0, 0, 0, 1);
        chk("rst_requal_rst", b + 5, 0, 0, 0, 0);
        chk("rst_requal_e6", b + 6, 0, 0, 0, 0);
        chk("rst_requal_e12", b + 12, 0, 0, 0, -1);
        chk("rst_requal_rise", b + 13, 1, 1, 0, 1, 0);
        chk("rst_requal_after", b + 14, 1, 0, 0, 0, 0);
        pad = 1'b1;
        edges(4);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        drain();

        // Capture: fall enabled only; clear alone
        th = 8'd3;
        start(b);
        chk("cap_fall", b + 6, 0, 0, 1, -1, 0);
        chk("cap_set", b + 7, 0, 0, 0, 0, 1);
        chk("cap_clr", b + 8, 0, 0, 0, 0, 0);
        pad = 1'b0;
        edges(7);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        drain();

        // Rise is not captured
        start(b);
        chk("cap_rise_e6", b + 6, 1, 1, 0, -1, 0);
        chk("cap_rise_e7", b + 7, 1, 0, 0, 0, 0);
        pad = 1'b1;
        drain();

        // Clear coincides with a new capture: set wins; then clear alone
        start(b);
        chk("cap_fall2", b + 6, 0, 0, 1, -1, 0);
        chk("cap_setwins", b + 7, 0, 0, 0, 0, 1);
        chk("cap_sticky", b + 8, 0, 0, 0, 0, 1);
        chk("cap_clr2", b + 9, 0, 0, 0, 0, 0);
        chk("cap_clr2_hold", b + 10, 0, 0, 0, 0, 0);
        pad = 1'b0;
        edges(6);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        edges(1);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
